alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Multi-byte operation sequencer for the 8-bit combinational ALU.
- Latches two NBYTES-wide operands and an opcode, then drives the external ALU one byte per cycle, chaining shift/carry between bytes.
- Assembles the wide result and flags, then pulses done.
- Sits between the control unit / multi-precision instruction logic and a single shared ALU instance.

Parameters:
NBYTES, 4, operand width in bytes (legal range >= 2); internal byte index is $clog2(NBYTES) bits

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only when busy=0
abort  input  1  synchronous cancel of an in-flight operation
op  input  4  opcode: 0000 add, 0001 left shift, 0010 right shift, 0011 move A, 0100 or, 0101 xor, 0110 and, 1000 sub (feature only)
cin  input  1  carry/shift-in for the first byte step
opa  input  8*NBYTES  operand A, byte 0 = LSB
opb  input  8*NBYTES  operand B
busy  output  1  high in RUN and DONE
done  output  1  one-cycle completion pulse
err  output  1  illegal opcode; holds until next accepted start
result  output  8*NBYTES  wide result; held until next accepted start
cout  output  1  final carry/shift-out
zero  output  1  result == 0
alu_cmd  output  4  to ALU
alu_a  output  8  to ALU inA
alu_b  output  8  to ALU inB
alu_sci  output  1  to ALU sc_i
alu_rslt  input  8  from ALU rslt
alu_sco  input  1  from ALU sc_o

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, err=0, result=0, cout=0, zero=0, idx=0. Reset mid-operation discards all progress; no done is issued.
- IDLE: ALU outputs are NOP: alu_cmd=1111, alu_a=0, alu_b=0, alu_sci=0.
- start while busy=0: latch op, cin, opa, opb. Clear err and zero-accumulator.
  - Legal op: go to RUN.
  - Illegal op: go to DONE with err=1, result=0, cout=0, zero=0, and no ALU cycles.
- start while busy=1: ignored; no side effects.
- RUN lasts exactly NBYTES cycles, one byte per cycle.
  - Order is LSB to MSB for add, sub, left shift and the logic ops; MSB to LSB for right shift.
  - First step: alu_sci=cin (forced 1 for sub). Later steps: alu_sci = carry register, which captures alu_sco each cycle.
  - Each cycle: alu_cmd=op (add for sub), alu_a=A byte, alu_b=B byte (~B byte for sub). alu_rslt is written into result byte[idx] at the clock edge.
  - result bytes not yet written are 0 during RUN.
  - On the last step, cout <= alu_sco. Logic/move ops set cout=0 regardless of alu_sco.
- DONE: one cycle. done=1, busy=1, zero = all result bytes zero; then IDLE.
- Latency: start accepted at edge 0 -> done high during cycle NBYTES+1 -> busy low in cycle NBYTES+2. Back-to-back start is accepted in the first IDLE cycle.
- abort in RUN: go to IDLE next edge. No done; result partially written; err=0. Abort is ignored in IDLE and DONE. If abort and start coincide in IDLE, start wins.
- Arithmetic: per-byte unsigned add with carry chain, so the wide sum is mod 2^(8*NBYTES) and cout is the carry out of the MSB.
- Sub: cout=1 means no borrow.

Optional Feature:
- Macro: ALU_SEQ_SUB_EN.
- Defined: op 1000 is subtract, computed as A + ~B + 1 using ALU add (0000) with inverted B bytes and forced initial carry-in of 1.
- Undefined: op 1000 is illegal (err=1, DONE after one cycle, no ALU activity); no inversion logic is synthesized.

Test Plan:
- NBYTES=4, add, opa=0x000000FF, opb=0x00000001, cin=0 -> done in cycle 5 after accept; result=0x00000100, cout=0, zero=0, err=0.
- add opa=0xFFFFFFFF, opb=0x00000001, cin=0 -> result=0x00000000, cout=1, zero=1. Same operands with cin=1 -> result=0x00000001, cout=1.
- left shift opa=0x80000001, cin=1 -> result=0x00000003, cout=1. Right shift opa=0x80000001, cin=0 -> result=0x40000000, cout=1. Check the alu_a byte order on the ALU port.
- xor opa=opb=0xA5A5A5A5 -> result=0, zero=1, cout=0. op=1010 -> err=1, done one cycle after accept, alu_cmd stays 1111.
- start pulsed while busy -> ignored, first result intact. abort on the 2nd RUN cycle -> no done, busy=0 next cycle. rst_n low mid-RUN -> all outputs 0 immediately (async).
- With ALU_SEQ_SUB_EN: sub 0x00000005-0x00000006 -> result=0xFFFFFFFF, cout=0. sub 0x00000006-0x00000005 -> result=0x00000001, cout=1. Without the macro: op=1000 -> err=1.

Source files
------------

// File: rtl/alu_seq.sv
// Multi-byte sequencer that drives a shared 8-bit ALU one byte per cycle.
// Define ALU_SEQ_SUB_EN to enable op 1000 (subtract as A + ~B + 1).
module alu_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [3:0]            op,
  input  logic                  cin,
  input  logic [8*NBYTES-1:0]   opa,
  input  logic [8*NBYTES-1:0]   opb,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout,
  output logic                  zero,
  output logic [3:0]            alu_cmd,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic                  alu_sci,
  input  logic [7:0]            alu_rslt,
  input  logic                  alu_sco
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SHR  = 4'b0010;
  localparam logic [3:0] OP_MOVA = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e                      r_state, w_state_nxt;
  logic [3:0]                  r_op;
  logic [NBYTES-1:0][7:0]      r_opa, r_opb, r_result;
  logic [IW-1:0]               r_idx;
  logic                        r_carry, r_cout, r_zero, r_err, r_nz;

  logic w_accept, w_op_legal, w_first_carry, w_is_sub, w_is_logic, w_last;

  assign w_accept   = start && (r_state == S_IDLE);
  assign w_is_logic = r_op inside {OP_MOVA, OP_OR, OP_XOR, OP_AND};
  assign w_last     = (r_op == OP_SHR) ? (r_idx == '0) : (r_idx == LAST_IDX);

`ifdef ALU_SEQ_SUB_EN
  assign w_op_legal    = (op <= OP_AND) || (op == OP_SUB);
  assign w_first_carry = (op == OP_SUB) ? 1'b1 : cin;
  assign w_is_sub      = (r_op == OP_SUB);
`else
  assign w_op_legal    = (op <= OP_AND);
  assign w_first_carry = cin;
  assign w_is_sub      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (start)   w_state_nxt = w_op_legal ? S_RUN : S_DONE;
      S_RUN:  if (abort)   w_state_nxt = S_IDLE;
              else if (w_last) w_state_nxt = S_DONE;
      S_DONE:              w_state_nxt = S_IDLE;
      default:             w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all registers sample the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_result <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
      r_nz     <= 1'b0;
    end else if (w_accept) begin
      r_op     <= op;
      r_opa    <= opa;
      r_opb    <= opb;
      r_result <= '0;
      r_idx    <= (op == OP_SHR) ? LAST_IDX : '0;
      r_carry  <= w_first_carry;
      r_cout   <= 1'b0;
      r_zero   <= 1'b0;
      r_err    <= ~w_op_legal;
      r_nz     <= 1'b0;
    end else if (r_state == S_RUN && !abort) begin
      r_result[r_idx] <= alu_rslt;
      r_carry         <= alu_sco;
      r_nz            <= r_nz | (|alu_rslt);
      if (w_last) begin
        // Logic and move ops have no meaningful carry, whatever the ALU reports.
        r_cout <= w_is_logic ? 1'b0 : alu_sco;
        r_zero <= ~(r_nz | (|alu_rslt));
      end else begin
        r_idx  <= (r_op == OP_SHR) ? r_idx - IW'(1) : r_idx + IW'(1);
      end
    end
  end

  always_comb begin
    alu_cmd = OP_NOP;
    alu_a   = 8'h00;
    alu_b   = 8'h00;
    alu_sci = 1'b0;
    if (r_state == S_RUN) begin
      alu_cmd = w_is_sub ? OP_ADD : r_op;
      alu_a   = r_opa[r_idx];
`ifdef ALU_SEQ_SUB_EN
      alu_b   = w_is_sub ? ~r_opb[r_idx] : r_opb[r_idx];
`else
      alu_b   = r_opb[r_idx];
`endif
      alu_sci = r_carry;
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign err    = r_err;
  assign result = r_result;
  assign cout   = r_cout;
  assign zero   = r_zero;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (NBYTES=4) with a behavioural 8-bit ALU model on the ALU port.
module tb_alu_seq;

  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort, cin;
  logic [3:0]    op;
  logic [31:0]   opa, opb;
  logic          busy, done, err, cout, zero, alu_sci, alu_sco;
  logic [31:0]   result;
  logic [3:0]    alu_cmd;
  logic [7:0]    alu_a, alu_b, alu_rslt;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] seq_a [NB];
  logic       saw_cmd;
  int         n;

  always #5 clk = ~clk;

  alu_seq #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .op(op), .cin(cin),
    .opa(opa), .opb(opb), .busy(busy), .done(done), .err(err), .result(result),
    .cout(cout), .zero(zero), .alu_cmd(alu_cmd), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sci(alu_sci), .alu_rslt(alu_rslt), .alu_sco(alu_sco)
  );

  // External ALU; logic/move ops return a junk carry of 1 that the sequencer must ignore.
  always_comb begin
    alu_rslt = 8'h00;
    alu_sco  = 1'b0;
    case (alu_cmd)
      4'b0000: {alu_sco, alu_rslt} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_sci};
      4'b0001: {alu_sco, alu_rslt} = {alu_a, alu_sci};
      4'b0010: begin alu_rslt = {alu_sci, alu_a[7:1]}; alu_sco = alu_a[0]; end
      4'b0011: begin alu_rslt = alu_a;         alu_sco = 1'b1; end
      4'b0100: begin alu_rslt = alu_a | alu_b; alu_sco = 1'b1; end
      4'b0101: begin alu_rslt = alu_a ^ alu_b; alu_sco = 1'b1; end
      4'b0110: begin alu_rslt = alu_a & alu_b; alu_sco = 1'b1; end
      default: begin alu_rslt = 8'h00;         alu_sco = 1'b0; end
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done with a cycle budget; n counts edges after the current point.
  task automatic wait_done(output int cnt);
    cnt = 0;
    saw_cmd = 1'b0;
    while (!done && cnt < 20) begin
      if (cnt < NB) seq_a[cnt] = alu_a;
      if (alu_cmd !== 4'hF) saw_cmd = 1'b1;
      tick();
      cnt++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic run_op(input logic [3:0] o, input logic c, input logic [31:0] a, input logic [31:0] b,
                        output int cnt);
    op = o; cin = c; opa = a; opb = b; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cnt);
  endtask

  task automatic finish_op(input string tag, input logic [31:0] exp_res);
    check({tag, "_busy_in_done"}, busy, 1);
    tick();
    check({tag, "_done_pulse"}, {busy, done}, 2'b00);
    check({tag, "_held"}, result, exp_res);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cin = 1'b0; op = 4'h0; opa = '0; opb = '0;
    #23;
    check("reset_outs", {busy, done, err, cout, zero, result}, '0);
    check("reset_alu", {alu_cmd, alu_a, alu_b, alu_sci}, {4'hF, 17'h0});
    rst_n = 1'b1;
    tick();

    // add with carry across byte 0 -> byte 1
    run_op(4'b0000, 1'b0, 32'h0000_00FF, 32'h0000_0001, n);
    check("add1_latency", n, NB);
    check("add1_res", {result, cout, zero, err}, {32'h0000_0100, 3'b000});
    finish_op("add1", 32'h0000_0100);

    // wrap-around: full carry chain
    run_op(4'b0000, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, n);
    check("add2_res", {result, cout, zero}, {32'h0, 2'b11});
    finish_op("add2", 32'h0);

    run_op(4'b0000, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, n);
    check("add3_res", {result, cout, zero}, {32'h0000_0001, 2'b10});
    finish_op("add3", 32'h0000_0001);

    // left shift: LSB first
    run_op(4'b0001, 1'b1, 32'h8000_0001, 32'h0, n);
    check("shl_res", {result, cout}, {32'h0000_0003, 1'b1});
    check("shl_order", {seq_a[0], seq_a[1], seq_a[2], seq_a[3]}, 32'h0100_0080);
    finish_op("shl", 32'h0000_0003);

    // right shift: MSB first
    run_op(4'b0010, 1'b0, 32'h8000_0001, 32'h0, n);
    check("shr_res", {result, cout}, {32'h4000_0000, 1'b1});
    check("shr_order", {seq_a[0], seq_a[1], seq_a[2], seq_a[3]}, 32'h8000_0001);
    finish_op("shr", 32'h4000_0000);

    run_op(4'b0101, 1'b0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, n);
    check("xor_res", {result, cout, zero}, {32'h0, 2'b01});
    finish_op("xor", 32'h0);

    run_op(4'b0110, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, n);
    check("and_res", {result, cout, zero}, {32'hF000_F000, 2'b00});
    finish_op("and", 32'hF000_F000);

    run_op(4'b0011, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF, n);
    check("mova_res", {result, cout}, {32'h1234_5678, 1'b0});
    finish_op("mova", 32'h1234_5678);

    // illegal opcode: straight to DONE, ALU untouched
    run_op(4'b1010, 1'b0, 32'h1234_5678, 32'h1, n);
    check("ill_latency", n, 0);
    check("ill_flags", {err, result, cout, zero}, {1'b1, 34'h0});
    check("ill_alu_cmd", alu_cmd, 4'hF);
    finish_op("ill", 32'h0);
    check("ill_err_hold", err, 1);

    run_op(4'b0100, 1'b0, 32'h0F00_0000, 32'h0000_00F0, n);
    check("or_res_err_clr", {result, err, saw_cmd}, {32'h0F00_00F0, 2'b01});
    finish_op("or", 32'h0F00_00F0);

`ifdef ALU_SEQ_SUB_EN
    run_op(4'b1000, 1'b0, 32'h0000_0005, 32'h0000_0006, n);
    check("sub1_res", {result, cout, err}, {32'hFFFF_FFFF, 2'b00});
    finish_op("sub1", 32'hFFFF_FFFF);
    run_op(4'b1000, 1'b0, 32'h0000_0006, 32'h0000_0005, n);
    check("sub2_res", {result, cout, err}, {32'h0000_0001, 2'b10});
    finish_op("sub2", 32'h0000_0001);
`else
    run_op(4'b1000, 1'b0, 32'h0000_0006, 32'h0000_0005, n);
    check("sub_ill", {n[7:0], err, result}, {8'd0, 1'b1, 32'h0});
    finish_op("sub_ill", 32'h0);
`endif

    // start while busy is ignored
    op = 4'b0000; cin = 1'b0; opa = 32'h0000_00FF; opb = 32'h0000_0001; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    op = 4'b0101; opa = 32'h1234_5678; opb = 32'h0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    check("busy_start_lat", n, NB - 2);
    check("busy_start_res", {result, err}, {32'h0000_0100, 1'b0});
    finish_op("busy_start", 32'h0000_0100);

    // abort on the second RUN cycle
    op = 4'b0000; opa = 32'h0101_0101; opb = 32'h0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", {busy, done, err}, 3'b000);
    saw_cmd = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done) saw_cmd = 1'b1;
      tick();
    end
    check("abort_no_done", saw_cmd, 0);

    // asynchronous reset mid-RUN
    op = 4'b0000; opa = 32'h0101_0101; opb = 32'h0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("pre_rst_partial", {busy, result}, {1'b1, 32'h0000_0001});
    rst_n = 1'b0;
    #1;
    check("async_rst_outs", {busy, done, err, cout, zero, result}, '0);
    check("async_rst_alu", alu_cmd, 4'hF);
    tick();
    rst_n = 1'b1;
    tick();

    run_op(4'b0000, 1'b0, 32'h1111_1111, 32'h2222_2222, n);
    check("post_rst_add", {result, cout, n[7:0]}, {32'h3333_3333, 1'b0, 8'd4});
    finish_op("post_rst", 32'h3333_3333);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
